rgb_led_sequencer: RTL and testbench

Parametrised RGB matrix driver with a single push-button, a debouncer, a mode state machine and a shared PWM engine. It generalises the fixed 25-LED chromatic driver to any LED count and PWM depth and adds solid-palette, hue-fade and blink modes, selected by button presses. It sits directly between the board button and the matrix anode/cathode pins.

---
 rtl/rgb_led_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_rgb_led_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_led_sequencer.sv
// RGB matrix driver: button debouncer, mode FSM (solid / fade / blink) and a shared PWM engine.
// Define RGB_SEQ_FADE_EN to include the hue-fade mode; without it presses alternate SOLID/BLINK.
module rgb_led_sequencer #(
  parameter int unsigned NUM_LEDS    = 25,
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned DEB_CYCLES  = 250000,
  parameter int unsigned STEP_CYCLES = 50000,
  parameter bit          OUT_INV     = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                btn_n,
  output logic [NUM_LEDS-1:0] R,
  output logic [NUM_LEDS-1:0] G,
  output logic [NUM_LEDS-1:0] B,
  output logic [1:0]          mode,
  output logic                frame_tick
);

  localparam int unsigned DW = $clog2(DEB_CYCLES);
  localparam int unsigned SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [DW-1:0]       DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] MAX       = '1;
  localparam logic [PWM_BITS-1:0] CNT_LAST  = MAX - 1'b1;
  localparam logic [PWM_BITS-1:0] HALF      = MAX >> 1;

  typedef enum logic [1:0] {StSolid = 2'd0, StFade = 2'd1, StBlink = 2'd2} mode_e;

  logic          sync1_q, sync2_q, stable_q, press_q;
  logic [DW-1:0] deb_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      stable_q  <= 1'b1;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == stable_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
        stable_q  <= sync2_q;
        deb_cnt_q <= '0;
        press_q   <= ~sync2_q;  // only the falling edge counts as a press
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end
  end

  logic [SW-1:0] step_cnt_q;
  logic          step_tick;
  assign step_tick = (step_cnt_q == STEP_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_cnt_q <= '0;
    end else begin
      step_cnt_q <= step_tick ? '0 : step_cnt_q + 1'b1;
    end
  end

  mode_e               state_q;
  logic [2:0]          color_q;
  logic [PWM_BITS-1:0] level_q;
  logic                blink_on_q;
`ifdef RGB_SEQ_FADE_EN
  logic [2:0]          sector_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StSolid;
      color_q    <= '0;
      level_q    <= '0;
      blink_on_q <= 1'b0;
`ifdef RGB_SEQ_FADE_EN
      sector_q   <= '0;
`endif
    end else if (press_q) begin
      // A mode change always wins over a coincident step tick.
      level_q    <= '0;
      blink_on_q <= 1'b1;
`ifdef RGB_SEQ_FADE_EN
      sector_q   <= '0;
`endif
      unique case (state_q)
`ifdef RGB_SEQ_FADE_EN
        StSolid: state_q <= StFade;
        StFade:  state_q <= StBlink;
`else
        StSolid: state_q <= StBlink;
`endif
        StBlink: begin
          state_q <= StSolid;
          color_q <= color_q + 3'd1;
        end
        default: state_q <= StSolid;
      endcase
    end else if (step_tick && state_q != StSolid) begin
      if (level_q == CNT_LAST) begin
        level_q <= '0;
        if (state_q == StBlink) blink_on_q <= ~blink_on_q;
`ifdef RGB_SEQ_FADE_EN
        if (state_q == StFade) sector_q <= (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
`endif
      end else begin
        level_q <= level_q + 1'b1;
      end
    end
  end

  logic [PWM_BITS-1:0] pal_r, pal_g, pal_b, tgt_r, tgt_g, tgt_b;

  always_comb begin
    pal_r = '0;
    pal_g = '0;
    pal_b = '0;
    unique case (color_q)
      3'd0: pal_r = MAX;
      3'd1: pal_g = MAX;
      3'd2: pal_b = MAX;
      3'd3: begin pal_r = MAX;  pal_g = MAX; end
      3'd4: begin pal_g = MAX;  pal_b = MAX; end
      3'd5: begin pal_r = MAX;  pal_b = MAX; end
      3'd6: begin pal_r = MAX;  pal_g = MAX;  pal_b = MAX;  end
      default: begin pal_r = HALF; pal_g = HALF; pal_b = HALF; end
    endcase

    tgt_r = '0;
    tgt_g = '0;
    tgt_b = '0;
    unique case (state_q)
      StSolid: begin tgt_r = pal_r; tgt_g = pal_g; tgt_b = pal_b; end
      StBlink: if (blink_on_q) begin tgt_r = pal_r; tgt_g = pal_g; tgt_b = pal_b; end
`ifdef RGB_SEQ_FADE_EN
      StFade: begin
        unique case (sector_q)
          3'd0: begin tgt_r = MAX;           tgt_g = level_q; end
          3'd1: begin tgt_r = MAX - level_q; tgt_g = MAX;     end
          3'd2: begin tgt_g = MAX;           tgt_b = level_q; end
          3'd3: begin tgt_g = MAX - level_q; tgt_b = MAX;     end
          3'd4: begin tgt_r = level_q;       tgt_b = MAX;     end
          default: begin tgt_r = MAX;        tgt_b = MAX - level_q; end
        endcase
      end
`endif
      default: ;
    endcase
  end

  logic [PWM_BITS-1:0] cnt_q, cnt_d, duty_r_q, duty_g_q, duty_b_q;
  logic                frame_tick_q, lit_r_q, lit_g_q, lit_b_q;

  assign cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      frame_tick_q <= 1'b0;
      duty_r_q     <= '0;
      duty_g_q     <= '0;
      duty_b_q     <= '0;
      lit_r_q      <= 1'b0;
      lit_g_q      <= 1'b0;
      lit_b_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      frame_tick_q <= (cnt_d == CNT_LAST);
      lit_r_q      <= (cnt_q < duty_r_q);
      lit_g_q      <= (cnt_q < duty_g_q);
      lit_b_q      <= (cnt_q < duty_b_q);
      if (cnt_q == CNT_LAST) begin
        duty_r_q <= tgt_r;
        duty_g_q <= tgt_g;
        duty_b_q <= tgt_b;
      end
    end
  end

  assign R          = {NUM_LEDS{lit_r_q ^ OUT_INV}};
  assign G          = {NUM_LEDS{lit_g_q ^ OUT_INV}};
  assign B          = {NUM_LEDS{lit_b_q ^ OUT_INV}};
  assign mode       = state_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Bench for rgb_led_sequencer: directed timing sequences, a button-press table and random
// button activity, all checked each cycle against a behavioural model of the sequencer.
module tb_rgb_led_sequencer;
  localparam int NL = 4, PB = 3, M = 7, DEB = 4, STEP = 2;
`ifdef RGB_SEQ_FADE_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 2;
`endif

  logic clk = 1'b0;
  logic reset_n, btn_n;
  logic [NL-1:0] R, G, B, Ri, Gi, Bi;
  logic [1:0] mode, mode_i;
  logic ft, ft_i;

  always #5 clk = ~clk;

  rgb_led_sequencer #(.NUM_LEDS(NL), .PWM_BITS(PB), .DEB_CYCLES(DEB), .STEP_CYCLES(STEP),
                      .OUT_INV(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .btn_n(btn_n), .R(R), .G(G), .B(B), .mode(mode),
    .frame_tick(ft));

  rgb_led_sequencer #(.NUM_LEDS(NL), .PWM_BITS(PB), .DEB_CYCLES(DEB), .STEP_CYCLES(STEP),
                      .OUT_INV(1'b1)) dut_inv (
    .clk(clk), .reset_n(reset_n), .btn_n(btn_n), .R(Ri), .G(Gi), .B(Bi), .mode(mode_i),
    .frame_tick(ft_i));

  // Behavioural model
  int pal_r[8] = '{M, 0, 0, M, 0, M, M, M / 2};
  int pal_g[8] = '{0, M, 0, M, M, 0, M, M / 2};
  int pal_b[8] = '{0, 0, M, 0, M, M, M, M / 2};
  int m_s1, m_s2, m_stable, m_run, m_press, m_mode, m_color, m_cycle, m_level, m_sector;
  int m_blink, m_cnt, m_dr, m_dg, m_db, m_lr, m_lg, m_lb;
  int t_r, t_g, t_b, n_press;
  bit tick;

  function automatic void target(output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    if (m_mode == 0 || (m_mode == 2 && m_blink != 0)) begin
      r = pal_r[m_color]; g = pal_g[m_color]; b = pal_b[m_color];
    end else if (m_mode == 1) begin
      case (m_sector)
        0: begin r = M;           g = m_level; end
        1: begin r = M - m_level; g = M;       end
        2: begin g = M;           b = m_level; end
        3: begin g = M - m_level; b = M;       end
        4: begin r = m_level;     b = M;       end
        default: begin r = M;     b = M - m_level; end
      endcase
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = 1; m_s2 = 1; m_stable = 1; m_run = 0; m_press = 0; m_mode = 0; m_color = 0;
      m_cycle = 0; m_level = 0; m_sector = 0; m_blink = 0; m_cnt = 0;
      m_dr = 0; m_dg = 0; m_db = 0; m_lr = 0; m_lg = 0; m_lb = 0;
    end else begin
      tick = (m_cycle % STEP) == STEP - 1;
      target(t_r, t_g, t_b);
      m_lr = int'(m_cnt < m_dr); m_lg = int'(m_cnt < m_dg); m_lb = int'(m_cnt < m_db);
      if (m_cnt == M - 1) begin
        m_dr = t_r; m_dg = t_g; m_db = t_b; m_cnt = 0;
      end else m_cnt++;
      if (m_press != 0) begin
        m_level = 0; m_sector = 0; m_blink = 1;
`ifdef RGB_SEQ_FADE_EN
        m_mode = (m_mode + 1) % 3;
`else
        m_mode = (m_mode == 0) ? 2 : 0;
`endif
        if (m_mode == 0) m_color = (m_color + 1) % 8;
      end else if (tick && m_mode != 0) begin
        m_level++;
        if (m_level == M) begin
          m_level = 0;
          if (m_mode == 1) m_sector = (m_sector + 1) % 6;
          else m_blink = 1 - m_blink;
        end
      end
      // stable follows sync once they have differed for DEB consecutive cycles
      n_press = 0;
      if (m_s2 != m_stable) begin
        m_run++;
        if (m_run == DEB) begin
          m_stable = m_s2; m_run = 0; n_press = int'(m_s2 == 0);
        end
      end else m_run = 0;
      m_s2 = m_s1; m_s1 = int'(btn_n);
      m_press = n_press;
      m_cycle++;
    end
  end

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [NL-1:0] er, eg, eb;
    logic [1:0] em;
    logic ef;
    er = (m_lr != 0) ? '1 : '0;
    eg = (m_lg != 0) ? '1 : '0;
    eb = (m_lb != 0) ? '1 : '0;
    em = 2'(m_mode);
    ef = (m_cnt == M - 1);
    chk("outputs", 32'({R, G, B, mode, ft}), 32'({er, eg, eb, em, ef}));
    chk("outputs_inv", 32'({Ri, Gi, Bi, mode_i, ft_i}), 32'({~er, ~eg, ~eb, em, ef}));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic press();
    btn_n = 1'b0;
    cyc(6);
    btn_n = 1'b1;
    cyc(10);
  endtask

  typedef struct {int low; int high; int exp_mode;} vec_t;
  vec_t vecs[6];

  initial begin
`ifdef RGB_SEQ_FADE_EN
    vecs[0] = '{3, 12, 0}; vecs[1] = '{4, 12, 1}; vecs[2] = '{2, 12, 1};
    vecs[3] = '{5, 12, 2}; vecs[4] = '{4, 12, 0}; vecs[5] = '{4, 12, 1};
`else
    vecs[0] = '{3, 12, 0}; vecs[1] = '{4, 12, 2}; vecs[2] = '{2, 12, 2};
    vecs[3] = '{5, 12, 0}; vecs[4] = '{4, 12, 2}; vecs[5] = '{4, 12, 0};
`endif
    reset_n = 1'b0;
    btn_n   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_R", 32'(R), 32'h0);
    chk("reset_R_inv", 32'(Ri), 32'hF);
    chk("reset_mode", 32'(mode), 32'h0);
    chk("reset_frame_tick", 32'(ft), 32'h0);
    reset_n = 1'b1;

    // First frame dark, solid red from the second frame, frame_tick every 7 cycles
    for (int i = 1; i <= 21; i++) begin
      cyc(1);
      chk("first_frames_R", 32'(R), (i < 8) ? 32'h0 : 32'hF);
      chk("first_frames_GB", 32'({G, B}), 32'h0);
      chk("frame_tick_period", 32'(ft), 32'((i % 7) == 6));
    end

    // Short bounce is ignored
    btn_n = 1'b0;
    cyc(3);
    btn_n = 1'b1;
    cyc(10);
    chk("bounce_mode", 32'(mode), 32'h0);

    // Press latency: mode changes exactly 7 cycles after the falling edge
    btn_n = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      if (k == 6) chk("press_latency_early", 32'(mode), 32'h0);
      if (k == 7) chk("press_latency", 32'(mode), 32'(FIRST));
    end
    cyc(3);
    btn_n = 1'b1;
    cyc(10);

    cyc(80);  // blink (or fade) windows, model-checked
    if (FIRST == 1) press();
    press();
    chk("back_to_solid", 32'(mode), 32'h0);
    cyc(20);
    for (int k = 0; k < 7; k++) begin
      cyc(1);
      chk("green_G", 32'(G), 32'hF);
      chk("green_RB", 32'({R, B}), 32'h0);
    end

    foreach (vecs[i]) begin
      btn_n = 1'b0;
      cyc(vecs[i].low);
      btn_n = 1'b1;
      cyc(vecs[i].high);
      chk("table_mode", 32'(mode), 32'(vecs[i].exp_mode));
    end

    for (int n = 0; n < 1500; ) begin
      int hold;
      hold  = int'($urandom_range(1, 9));
      btn_n = 1'($urandom_range(0, 1));
      cyc(hold);
      n += hold;
    end
    btn_n = 1'b1;
    cyc(20);

    // Asynchronous reset mid-frame while red is lit
    reset_n = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(12);
    chk("pre_reset_R", 32'(R), 32'hF);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_R", 32'(R), 32'h0);
    chk("async_reset_R_inv", 32'(Ri), 32'hF);
    chk("async_reset_mode", 32'(mode), 32'h0);
    check_all();

    // Button held through reset release gives exactly one press
    @(negedge clk);
    btn_n = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(30);
    chk("held_reset_press", 32'(mode), 32'(FIRST));
    cyc(40);
    chk("held_reset_single", 32'(mode), 32'(FIRST));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
